// File: rtl/alu_seq.sv
// alu_seq -- multi-byte arithmetic sequencer driving an 8-bit ALU.
//
// A command (op, invert, initial carry, byte count minus 1) starts a word.
// Operand byte pairs arrive LSB first over a valid/ready handshake. Each
// pair goes to the ALU for one cycle, and the ALU carry flag is chained
// into the next byte. Result bytes stream out over a second valid/ready
// handshake. A one-cycle done pulse ends the word, and the aggregate
// flags are then presented on flags.
//
// Parameters:
//   LEN_W       width of the length field; a word is 1..2^LEN_W bytes
// Ports:
//   clk, rst_n  clock (rising edge); asynchronous active-low reset
//   start       command strobe, sampled only when idle
//   cmd_op/cmd_invert/cmd_carry/cmd_len   command fields, latched on start
//   busy        high whenever a word is in progress
//   in_valid/in_ready/in_a/in_b           operand byte stream
//   alu_a/alu_b/alu_op/alu_invert/alu_carry/alu_n_oe   ALU drive
//   alu_result/alu_flags                  ALU response {ovf, sign, carry, zero}
//   out_valid/out_ready/out_data/out_last result byte stream
//   done        one-cycle completion pulse
//   flags       aggregate word flags {ovf, sign, carry, zero}
//
// Build option: define ALU_SEQ_ABORT_EN to add an abort input. Abort
// returns the sequencer to idle on the next edge, with no done pulse and
// with flags left unchanged.
module alu_seq #(
  parameter int LEN_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       cmd_op,
  input  logic             cmd_invert,
  input  logic             cmd_carry,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic [3:0]       alu_op,
  output logic             alu_invert,
  output logic             alu_carry,
  output logic             alu_n_oe,
  input  logic [7:0]       alu_result,
  input  logic [3:0]       alu_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_last,
  output logic             done,
`ifdef ALU_SEQ_ABORT_EN
  input  logic             abort,
`endif
  output logic [3:0]       flags
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_EXEC, S_OUT, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic             inv_q, inv_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             sign_q, sign_d;
  logic             ovf_q, ovf_d;
  logic [7:0]       a_q, a_d;
  logic [7:0]       b_q, b_d;
  logic [7:0]       data_q, data_d;
  logic [3:0]       flags_q, flags_d;
  logic             busy_q, busy_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic             done_q, done_d;
  logic             n_oe_q, n_oe_d;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    inv_d   = inv_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    sign_d  = sign_q;
    ovf_d   = ovf_q;
    a_d     = a_q;
    b_d     = b_q;
    data_d  = data_q;
    flags_d = flags_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = cmd_op;
          inv_d   = cmd_invert;
          len_d   = cmd_len;
          cnt_d   = '0;
          carry_d = cmd_carry;
          zero_d  = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        // The word is zero only if every byte is zero; sign and overflow
        // only matter for the most significant byte, so the last one wins.
        data_d  = alu_result;
        carry_d = alu_flags[1];
        zero_d  = zero_q & alu_flags[0];
        sign_d  = alu_flags[2];
        ovf_d   = alu_flags[3];
        state_d = S_OUT;
      end
      S_OUT: begin
        if (out_ready) begin
          if (cnt_q == len_q) begin
            state_d = S_DONE;
          end else begin
            // Only incremented below len, so it never wraps.
            cnt_d   = cnt_q + 1'b1;
            state_d = S_LOAD;
          end
        end
      end
      S_DONE: begin
        flags_d = {ovf_q, sign_q, carry_q, zero_q};
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

`ifdef ALU_SEQ_ABORT_EN
    // Abort overrides any handshake completing in the same cycle.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      flags_d = flags_q;
    end
`endif

    // Status outputs are decoded from the next state so they are registered.
    busy_d      = (state_d != S_IDLE);
    out_valid_d = (state_d == S_OUT);
    out_last_d  = (state_d == S_OUT) && (cnt_d == len_d);
    done_d      = (state_d == S_DONE);
    n_oe_d      = (state_d != S_EXEC);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      inv_q       <= 1'b0;
      len_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      sign_q      <= 1'b0;
      ovf_q       <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      data_q      <= '0;
      flags_q     <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      n_oe_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      inv_q       <= inv_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
      sign_q      <= sign_d;
      ovf_q       <= ovf_d;
      a_q         <= a_d;
      b_q         <= b_d;
      data_q      <= data_d;
      flags_q     <= flags_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
      n_oe_q      <= n_oe_d;
    end
  end

  // in_ready depends on state only, never on in_valid.
  assign in_ready   = (state_q == S_LOAD);
  assign busy       = busy_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_op     = op_q;
  assign alu_invert = inv_q;
  assign alu_carry  = carry_q;
  assign alu_n_oe   = n_oe_q;
  assign out_valid  = out_valid_q;
  assign out_data   = data_q;
  assign out_last   = out_last_q;
  assign done       = done_q;
  assign flags      = flags_q;

endmodule

// File: doc/alu_seq.md
# alu_seq

Multi-byte arithmetic sequencer that drives the 8-bit ALU as its initiator. It accepts a command (op, invert, initial carry, length) and consumes a stream of operand byte pairs, least-significant byte first. For each byte pair it presents the operands to the ALU, chains the ALU carry flag into the next byte, and streams result bytes out. At completion it reports aggregate flags for the whole N-byte word. It sits between the microcode/control unit and the ALU, and handles 16/24/32-bit operations on the 8-bit datapath.

## Interface
Parameters:
- LEN_W, 2: width of length field; word length is 1..2^LEN_W bytes

Ports:
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  command strobe; sampled only in IDLE
- cmd_op  in  4  ALU op code, latched on start
- cmd_invert  in  1  ALU invert, latched on start
- cmd_carry  in  1  carry into byte 0, latched on start
- cmd_len  in  LEN_W  byte count minus 1, latched on start
- busy  out  1  high in every state except IDLE
- in_valid / in_ready  in / out  1 / 1  operand handshake
- in_a, in_b  in  8 each  operand bytes
- alu_a, alu_b  out  8 each  registered ALU operands
- alu_op  out  4  latched op
- alu_invert  out  1  latched invert
- alu_carry  out  1  current chained carry
- alu_n_oe  out  1  ALU output enable, active-low
- alu_result  in  8  ALU result
- alu_flags  in  4  ALU flags {overflow, sign, carry, zero}
- out_valid / out_ready  out / in  1 / 1  result handshake
- out_data  out  8  result byte
- out_last  out  1  high with the final result byte
- done  out  1  one-cycle pulse at completion
- flags  out  4  aggregate flags, same bit order as alu_flags

## Operation
- States: IDLE, LOAD, EXEC, OUT, DONE.
- IDLE: on start, latch cmd_* into registers, clear the byte counter, set carry_reg = cmd_carry and zero_acc = 1, then go to LOAD.
- LOAD: in_ready = 1. On in_valid, register in_a/in_b into alu_a/alu_b, then go to EXEC.
- EXEC: alu_n_oe = 0 for exactly this cycle. Capture:
  - alu_result into out_data
  - carry_reg <= alu_flags[1]
  - zero_acc <= zero_acc & alu_flags[0]
  - sign and overflow from alu_flags[2]/[3]
  - then go to OUT.
- OUT: out_valid = 1 and out_last = (counter == len). On out_ready:
  - if last, go to DONE
  - otherwise increment the counter and go to LOAD.
- DONE: done = 1 for one cycle. flags <= {ovf_last, sign_last, carry_reg, zero_acc}. Return to IDLE.
- alu_carry always equals carry_reg, so byte k>0 uses the carry flag of byte k-1.
- flags holds its value until the next DONE.
- start is ignored while busy. Input data offered outside LOAD is not accepted.
- Reset values:
  - state IDLE
  - busy, in_ready, out_valid, out_last, done: 0
  - alu_n_oe = 1
  - alu_a, alu_b, alu_op, out_data, flags: 0
  - alu_invert, alu_carry: 0
- Reset mid-operation drops the word immediately: no done, and flags return to 0.

## Timing
- Per byte: 1 cycle in LOAD (when in_valid is already high), 1 in EXEC, at least 1 in OUT. Minimum 3 cycles per byte.
- Full word of N bytes: start-to-done minimum 3N+2 cycles, counting the IDLE start cycle and DONE.
- out_valid rises the cycle after EXEC. If out_ready is already high, the byte transfers in that first cycle.
- out_data and out_last are stable while out_valid is high and out_ready is low.
- in_ready is high only in LOAD. It is combinational from state, with no dependence on in_valid.
- Counter wrap: with cmd_len = 2^LEN_W-1 the counter reaches its maximum on the last byte and is never incremented past it.

## Configuration
- ALU_SEQ_ABORT_EN defined:
  - adds input port abort (1 bit)
  - abort high in any state except IDLE forces IDLE on the next edge
  - no done pulse; flags unchanged; out_valid and in_ready drop; alu_n_oe returns to 1
  - abort has priority over every handshake completing in the same cycle
  - abort in IDLE is ignored
- Undefined: port absent, and a word always runs to completion or reset.

## Test plan
- 16-bit add: op=add, cmd_len=1, carry=0, bytes (0xFF,0x01) then (0x00,0x00), out_ready tied high.
  - Expect out bytes 0x00, 0x01, alu_carry=1 on byte 1, flags carry=0, zero=0, done 8 cycles after start.
- 16-bit add producing zero: (0xFF,0x01) then (0xFF,0x00), carry=0.
  - Expect out bytes 0x00, 0x00 and flags zero=1, carry=1.
- Backpressure: cmd_len=2, out_ready low 4 cycles on byte 1.
  - Expect out_data stable and in_ready low throughout, and no byte lost or duplicated.
- start while busy: pulse start during EXEC with different cmd_op.
  - Expect alu_op unchanged and only one done.
- Reset mid-word: assert rst_n=0 in OUT of byte 1.
  - Expect all outputs at their reset values immediately. A following 1-byte op completes normally.
- With ALU_SEQ_ABORT_EN, abort in LOAD of byte 2.
  - Expect IDLE next cycle, no done, and flags equal to their previous value.
